// File: rtl/divider_pkg.sv
// Shared definitions for the sequential restoring divider: FSM encoding,
// default operand width and the iteration-counter width.
package divider_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      CALC = 2'b01,
      DONE = 2'b10
   } state_t;

   localparam int DEF_WIDTH = 8;

   // Counter must hold 2*w itself, hence the +1.
   function automatic int cnt_width(input int w);
      return $clog2(2 * w + 1);
   endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in the next dividend bit, then
// subtract the divisor if it fits. Pure combinational.
module div_step #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] i_prem,
   input  logic             i_bit,
   input  logic [WIDTH-1:0] i_divisor,
   output logic [WIDTH-1:0] o_prem,
   output logic             o_qbit
);

   logic [WIDTH:0]   w_t;
   logic             w_ge;
   logic [WIDTH-1:0] w_diff;

   assign w_t    = {i_prem, i_bit};
   assign w_ge   = (w_t >= {1'b0, i_divisor});
   // t < 2*divisor, so t - divisor fits in WIDTH bits; modular subtract is exact.
   assign w_diff = w_t[WIDTH-1:0] - i_divisor;

   assign o_prem = w_ge ? w_diff : w_t[WIDTH-1:0];
   assign o_qbit = w_ge;

endmodule

// File: rtl/seq_divider.sv
// Sequential restoring divider, one quotient bit per clock, with a level
// start / done handshake shared with the shift-add multiplier.
module seq_divider
   import divider_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 start,
   input  logic [2*WIDTH-1:0]   dividend,
   input  logic [WIDTH-1:0]     divisor,
   output logic [2*WIDTH-1:0]   quotient,
   output logic [WIDTH-1:0]     remainder,
   output logic                 done,
   output logic                 div_by_zero
);

   localparam int DW    = 2 * WIDTH;
   localparam int CNT_W = cnt_width(WIDTH);

   state_t           r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [DW-1:0]    r_dvd_sr;
   logic [WIDTH-1:0] r_div;
   logic [WIDTH-1:0] r_prem;

   logic [WIDTH-1:0] w_prem;
   logic             w_qbit;

   div_step #(.WIDTH(WIDTH)) u_step (
      .i_prem    (r_prem),
      .i_bit     (r_dvd_sr[DW-1]),
      .i_divisor (r_div),
      .o_prem    (w_prem),
      .o_qbit    (w_qbit)
   );

   // Quotient bits enter the dividend shift register from the LSB as the
   // dividend bits leave from the MSB; after 2*WIDTH shifts it holds the quotient.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= IDLE;
         r_cnt       <= '0;
         r_dvd_sr    <= '0;
         r_div       <= '0;
         r_prem      <= '0;
         quotient    <= '0;
         remainder   <= '0;
         done        <= 1'b0;
         div_by_zero <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_dvd_sr <= dividend;
                  r_div    <= divisor;
                  r_prem   <= '0;
                  r_cnt    <= CNT_W'(DW);
                  if (divisor == '0) begin
                     quotient    <= '1;
                     remainder   <= '0;
                     div_by_zero <= 1'b1;
                     done        <= 1'b1;
                     r_state     <= DONE;
                  end else begin
                     r_state <= CALC;
                  end
               end
            end
            CALC: begin
               r_prem   <= w_prem;
               r_dvd_sr <= {r_dvd_sr[DW-2:0], w_qbit};
               r_cnt    <= r_cnt - CNT_W'(1);
               if (r_cnt == CNT_W'(1)) begin
                  quotient    <= {r_dvd_sr[DW-2:0], w_qbit};
                  remainder   <= w_prem;
                  div_by_zero <= 1'b0;
                  done        <= 1'b1;
                  r_state     <= DONE;
               end
            end
            DONE: begin
               if (!start) begin
                  done    <= 1'b0;
                  r_state <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Sequential restoring divider; the inverse of the team's 8x8 shift-add multiplier.
- Takes a 2W-bit dividend (e.g. a 16-bit product) and a W-bit divisor. Returns a 2W-bit quotient and a W-bit remainder.
- Uses the same level-start / done handshake as the multiplier, so either block can sit behind the same controller or bench.
- Resolves one quotient bit per clock.

Parameters:
- WIDTH, 8, divisor and remainder width; dividend and quotient are 2*WIDTH.

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  level request; sampled only in IDLE
- dividend  in  2*WIDTH  numerator, captured on the accepting edge
- divisor  in  WIDTH  denominator, captured on the accepting edge
- quotient  out  2*WIDTH  registered result
- remainder  out  WIDTH  registered result
- done  out  1  high while in DONE
- div_by_zero  out  1  registered flag, valid when done=1

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE.
  - quotient=0, remainder=0, done=0, div_by_zero=0.
  - All internal working registers cleared.
  - Reset mid-operation abandons the division; no partial result appears.
- States: IDLE, CALC, DONE.
- IDLE:
  - Edge E0 with start=1 captures dividend into the shift register and divisor into the divisor register, and clears the partial remainder.
  - Loads count=2*WIDTH and goes to CALC.
  - If divisor==0 at E0, goes straight to DONE instead, with quotient=all ones, remainder=0, div_by_zero=1.
- CALC: one iteration per edge.
  - t = {partial_rem[WIDTH-1:0], dvd_sr[MSB]}, WIDTH+1 bits.
  - If t >= divisor: partial_rem = t - divisor, shifted-in quotient bit = 1.
  - Otherwise: partial_rem = t, shifted-in quotient bit = 0.
  - dvd_sr shifts left each edge; the quotient bits fill in from the LSB.
  - count decrements; on the edge where count reaches 0, load quotient, remainder and div_by_zero=0, then enter DONE.
- Latency:
  - done rises after edge E(2*WIDTH), i.e. 16 clocks after E0 for WIDTH=8.
  - Divide-by-zero: done rises after E0 (1 clock).
- DONE:
  - done=1; outputs held.
  - Stays in DONE while start=1; goes to IDLE on the first edge with start=0.
  - A held start therefore never triggers a second operation.
- Handshake and output timing:
  - quotient and remainder change only on the edge entering DONE; they hold their values through IDLE until the next completion.
  - done drops on the edge leaving DONE.
  - dividend/divisor changes after E0 are ignored until the next accept.
  - start is ignored in CALC.
- Arithmetic:
  - Unsigned only. Compare and subtract use WIDTH+1 bits; no overflow is possible.
  - Final remainder < divisor. Identity: dividend = quotient*divisor + remainder.
- Boundaries:
  - dividend < divisor: quotient=0, remainder=dividend.
  - divisor=1: quotient=dividend, remainder=0, full 2W width used.
  - dividend=0: quotient=0, remainder=0, full latency still taken.

Decomposition:
- Package divider_pkg holds:
  - the state encoding (IDLE=2'b00, CALC=2'b01, DONE=2'b10);
  - default WIDTH;
  - the count width constant clog2(2*WIDTH+1).
- One combinational sub-module, div_step: inputs partial_rem, next dividend bit, divisor; outputs new partial_rem and quotient bit. It keeps the datapath reusable for a future unrolled or pipelined divider.
- FSM, counter and output registers live in seq_divider.

Test Plan:
- Clock period 100, release reset at 150. Each case applies operands, holds start=1 until done, then drops start.
- 1170/45 -> quotient=26, remainder=0, done high exactly 16 clocks after E0; no new op while start stays high.
- 17900/179 -> quotient=100, remainder=0. 11348/57 -> quotient=199, remainder=5. div_by_zero=0 in each.
- 65535/1 -> quotient=16'hFFFF, remainder=0. 7/200 -> quotient=0, remainder=7.
- 1234/0 -> done one clock after E0, quotient=16'hFFFF, remainder=0, div_by_zero=1. The next op, 100/3, returns quotient=33, remainder=1 with div_by_zero=0.
- Reset mid-op:
  - Start 50000/7, assert reset_n=0 at iteration 8: all outputs 0 and state IDLE immediately.
  - After release, 50000/7 -> quotient=7142, remainder=6.
  - Also change the operand inputs during CALC; the result must be unaffected.
